// File: rtl/rail_pkg.sv
// Shared definitions for the rail crossing blocks: detector state encoding,
// default detector parameters and the signal light codes.
package rail_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OCC   = 2'd1,
    FAULT = 2'd2
  } det_state_t;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } light_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_MAX_TRAINS      = 3;
  localparam int DEF_TIMEOUT_CYCLES  = 1024;

endpackage

// File: rtl/sensor_debounce.sv
// One track sensor: 2-flop synchronizer, counting debouncer and a registered
// one-cycle pulse on each 0->1 change of the filtered value.
module sensor_debounce
  import rail_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic clr,
  input  logic raw,
  output logic filt,
  output logic rise
);

  // The last count before the filtered value flips; reaching it with the
  // input still different completes DEBOUNCE_CYCLES stable cycles.
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync1;
  logic       sync2;
  logic [7:0] cnt;

  // Bring the asynchronous sensor into the clk domain.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Filter: accept a new level only after it has persisted; the rise pulse is
  // registered together with the filtered value so it lines up with it.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      filt <= 1'b0;
      rise <= 1'b0;
      cnt  <= '0;
    end else begin
      rise <= 1'b0;
      if (sync2 == filt) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        filt <= sync2;
        rise <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/train_presence_detector.sv
// Counts trains between the approach and exit sensors and drives the gate
// controller's train input; any doubt about the count keeps train asserted.
module train_presence_detector
  import rail_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int MAX_TRAINS      = DEF_MAX_TRAINS,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       approach_raw,
  input  logic       exit_raw,
  input  logic       fault_ack,
  output logic       train,
  output logic [3:0] occupancy,
  output logic       fault,
  output logic       overflow
);

  // Timer is a down-counter: loaded with TIMEOUT_CYCLES-1, the timeout fires
  // on the edge after it hits zero, i.e. TIMEOUT_CYCLES edges after the load.
  localparam int            TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    MAX_OCC  = 4'(MAX_TRAINS);

  logic          app_filt;
  logic          app_rise;
  logic          ext_filt;
  logic          ext_rise;
  det_state_t    state;
  det_state_t    state_nxt;
  logic [TW-1:0] tmr;
  logic [TW-1:0] tmr_nxt;
  logic [3:0]    occ_nxt;
  logic          ovf_nxt;
  logic          arr_only;
  logic          dep_only;
  logic          event_any;
  logic          unexpected;
  logic          timeout;
  logic          ack_ok;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_approach (
    .clk  (clk),
    .clr  (clr),
    .raw  (approach_raw),
    .filt (app_filt),
    .rise (app_rise)
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit (
    .clk  (clk),
    .clr  (clr),
    .raw  (exit_raw),
    .filt (ext_filt),
    .rise (ext_rise)
  );

  // Next count, flags, state and timer from the current events.
  always_comb begin
    arr_only   = app_rise & ~ext_rise;
    dep_only   = ext_rise & ~app_rise;
    event_any  = app_rise | ext_rise;
    unexpected = dep_only && (occupancy == 4'd0);
    timeout    = (state == OCC) && !event_any && (tmr == '0);
    ack_ok     = (state == FAULT) && fault_ack && !app_filt && !ext_filt;

    occ_nxt = occupancy;
    ovf_nxt = overflow;
    if (arr_only) begin
      if (occupancy == MAX_OCC) ovf_nxt = 1'b1;
      else                      occ_nxt = occupancy + 4'd1;
    end else if (dep_only && (occupancy != 4'd0)) begin
      occ_nxt = occupancy - 4'd1;
    end

    state_nxt = state;
    case (state)
      IDLE: begin
        if (unexpected)                                 state_nxt = FAULT;
        else if (arr_only && (occupancy != MAX_OCC))    state_nxt = OCC;
      end
      OCC: begin
        if (unexpected || timeout)                      state_nxt = FAULT;
        else if (dep_only && (occupancy == 4'd1))       state_nxt = IDLE;
      end
      FAULT: begin
        if (ack_ok)                                     state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // An accepted acknowledge wipes the count; sensors are quiet so no event
    // can coincide with it.
    if (ack_ok) begin
      occ_nxt = 4'd0;
      ovf_nxt = 1'b0;
    end

    if ((state == OCC) && (state_nxt == OCC) && !event_any) tmr_nxt = tmr - 1'b1;
    else                                                    tmr_nxt = TMR_LOAD;
  end

  // Detector FSM with registered count, flags and decoded outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      occupancy <= 4'd0;
      overflow  <= 1'b0;
      fault     <= 1'b0;
      train     <= 1'b0;
      tmr       <= '0;
    end else begin
      state     <= state_nxt;
      occupancy <= occ_nxt;
      overflow  <= ovf_nxt;
      fault     <= (state_nxt == FAULT);
      train     <= (state_nxt != IDLE);
      tmr       <= tmr_nxt;
    end
  end

endmodule

// File: tb/tb_train_presence_detector.sv
// Directed bench for train_presence_detector: a default-parameter instance
// plus a short-timeout instance for the timeout scenario.
module tb_train_presence_detector;

  logic       clk;
  logic       clr;
  logic       a_raw, e_raw, ack;
  logic       train, fault, ovf;
  logic [3:0] occ;
  logic       a_raw_t, e_raw_t, ack_t;
  logic       train_t, fault_t, ovf_t;
  logic [3:0] occ_t;

  int tests;
  int fails;

  train_presence_detector dut (
    .clk          (clk),
    .clr          (clr),
    .approach_raw (a_raw),
    .exit_raw     (e_raw),
    .fault_ack    (ack),
    .train        (train),
    .occupancy    (occ),
    .fault        (fault),
    .overflow     (ovf)
  );

  train_presence_detector #(.TIMEOUT_CYCLES(20)) dut_t (
    .clk          (clk),
    .clr          (clr),
    .approach_raw (a_raw_t),
    .exit_raw     (e_raw_t),
    .fault_ack    (ack_t),
    .train        (train_t),
    .occupancy    (occ_t),
    .fault        (fault_t),
    .overflow     (ovf_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_approach(input int hi, input int lo);
    a_raw = 1'b1;
    tick(hi);
    a_raw = 1'b0;
    tick(lo);
  endtask

  task automatic test_reset;
    tick(2);
    tests++; if (train !== 1'b0) begin fails++; $display("FAIL reset_train got %0b expected 0", train); end
    tests++; if (occ !== 4'd0) begin fails++; $display("FAIL reset_occ got %0d expected 0", occ); end
    tests++; if (fault !== 1'b0) begin fails++; $display("FAIL reset_fault got %0b expected 0", fault); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got %0b expected 0", ovf); end
    tests++; if ({train_t, fault_t, ovf_t, occ_t} !== 7'd0) begin fails++; $display("FAIL reset_t got %0h expected 0", {train_t, fault_t, ovf_t, occ_t}); end
    clr = 1'b0;
    tick(3);
    tests++; if (train !== 1'b0) begin fails++; $display("FAIL post_reset_train got %0b expected 0", train); end
  endtask

  task automatic test_single_train;
    int t_rise = -1;
    int t_fall = -1;
    a_raw = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (train === 1'b1 && t_rise < 0) t_rise = i;
    end
    a_raw = 1'b0;
    tests++; if (t_rise != 7) begin fails++; $display("FAIL single_rise_tick got %0d expected 7", t_rise); end
    tests++; if (occ !== 4'd1) begin fails++; $display("FAIL single_occ_in got %0d expected 1", occ); end
    tick(50);
    tests++; if (train !== 1'b1) begin fails++; $display("FAIL single_train_hold got %0b expected 1", train); end
    e_raw = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (train === 1'b0 && t_fall < 0) t_fall = i;
    end
    e_raw = 1'b0;
    tests++; if (t_fall != 7) begin fails++; $display("FAIL single_fall_tick got %0d expected 7", t_fall); end
    tests++; if (occ !== 4'd0) begin fails++; $display("FAIL single_occ_out got %0d expected 0", occ); end
    tests++; if (fault !== 1'b0) begin fails++; $display("FAIL single_fault got %0b expected 0", fault); end
    tick(10);
  endtask

  task automatic test_glitch;
    for (int p = 0; p < 3; p++) begin
      int bad = 0;
      a_raw = 1'b1;
      for (int i = 0; i < 3; i++) begin
        tick(1);
        if (occ !== 4'd0 || train !== 1'b0) bad++;
      end
      a_raw = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick(1);
        if (occ !== 4'd0 || train !== 1'b0) bad++;
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL glitch_%0d got %0d bad cycles expected 0", p, bad); end
    end
  endtask

  task automatic test_saturation;
    for (int n = 1; n <= 3; n++) pulse_approach(10, 10);
    tests++; if (occ !== 4'd3) begin fails++; $display("FAIL sat_occ3 got %0d expected 3", occ); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL sat_ovf3 got %0b expected 0", ovf); end
    pulse_approach(10, 10);
    tests++; if (occ !== 4'd3) begin fails++; $display("FAIL sat_occ4 got %0d expected 3", occ); end
    tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL sat_ovf4 got %0b expected 1", ovf); end
    tests++; if (train !== 1'b1) begin fails++; $display("FAIL sat_train got %0b expected 1", train); end
    tests++; if (fault !== 1'b0) begin fails++; $display("FAIL sat_fault got %0b expected 0", fault); end
  endtask

  task automatic test_reset_mid;
    clr = 1'b1;
    #2;
    clr = 1'b0;
    tick(2);
    pulse_approach(10, 10);
    pulse_approach(10, 10);
    tests++; if (occ !== 4'd2) begin fails++; $display("FAIL mid_occ_pre got %0d expected 2", occ); end
    tests++; if (train !== 1'b1) begin fails++; $display("FAIL mid_train_pre got %0b expected 1", train); end
    #2;
    clr = 1'b1;
    #1;
    tests++; if (train !== 1'b0) begin fails++; $display("FAIL mid_train_now got %0b expected 0", train); end
    tests++; if (occ !== 4'd0) begin fails++; $display("FAIL mid_occ_now got %0d expected 0", occ); end
    tests++; if (fault !== 1'b0 || ovf !== 1'b0) begin fails++; $display("FAIL mid_flags_now got %0b%0b expected 00", fault, ovf); end
    tick(1);
    clr = 1'b0;
    tick(20);
    tests++; if (train !== 1'b0) begin fails++; $display("FAIL mid_train_after got %0b expected 0", train); end
    tests++; if (occ !== 4'd0) begin fails++; $display("FAIL mid_occ_after got %0d expected 0", occ); end
  endtask

  task automatic test_unexpected_departure;
    e_raw = 1'b1;
    tick(10);
    e_raw = 1'b0;
    tests++; if (fault !== 1'b1) begin fails++; $display("FAIL unexp_fault got %0b expected 1", fault); end
    tests++; if (train !== 1'b1) begin fails++; $display("FAIL unexp_train got %0b expected 1", train); end
    tests++; if (occ !== 4'd0) begin fails++; $display("FAIL unexp_occ got %0d expected 0", occ); end
    tick(10);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    tests++; if ({train, fault, ovf, occ} !== 7'd0) begin fails++; $display("FAIL unexp_ack got %0h expected 0", {train, fault, ovf, occ}); end
  endtask

  task automatic test_timeout;
    int t_inc = -1;
    int t_flt = -1;
    a_raw_t = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick(1);
      if (i == 10) a_raw_t = 1'b0;
      if (occ_t === 4'd1 && t_inc < 0) t_inc = i;
      if (fault_t === 1'b1 && t_flt < 0) t_flt = i;
    end
    tests++; if (t_inc != 7) begin fails++; $display("FAIL tmo_inc_tick got %0d expected 7", t_inc); end
    tests++; if (t_flt != 27) begin fails++; $display("FAIL tmo_fault_tick got %0d expected 27", t_flt); end
    tests++; if (occ_t !== 4'd1) begin fails++; $display("FAIL tmo_occ got %0d expected 1", occ_t); end
    tests++; if (train_t !== 1'b1) begin fails++; $display("FAIL tmo_train got %0b expected 1", train_t); end
    e_raw_t = 1'b1;
    tick(10);
    ack_t = 1'b1;
    tick(1);
    ack_t = 1'b0;
    tick(1);
    tests++; if (fault_t !== 1'b1) begin fails++; $display("FAIL tmo_ack_ignored_fault got %0b expected 1", fault_t); end
    tests++; if (train_t !== 1'b1) begin fails++; $display("FAIL tmo_ack_ignored_train got %0b expected 1", train_t); end
    e_raw_t = 1'b0;
    tick(10);
    ack_t = 1'b1;
    tick(1);
    ack_t = 1'b0;
    tests++; if ({train_t, fault_t, ovf_t, occ_t} !== 7'd0) begin fails++; $display("FAIL tmo_ack_clear got %0h expected 0", {train_t, fault_t, ovf_t, occ_t}); end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    clr     = 1'b1;
    a_raw   = 1'b0;
    e_raw   = 1'b0;
    ack     = 1'b0;
    a_raw_t = 1'b0;
    e_raw_t = 1'b0;
    ack_t   = 1'b0;
    test_reset;
    test_single_train;
    test_glitch;
    test_saturation;
    test_reset_mid;
    test_unexpected_departure;
    test_timeout;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/train_presence_detector.md
# train_presence_detector

Generates the debounced `train` presence input consumed by the rail gate controller. It takes two raw track sensors: an approach sensor upstream of the crossing and an exit sensor downstream. It counts trains in the protected section and holds `train` asserted while the section is occupied or in fault. Any uncertainty in the count resolves toward "train present".

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized cycles required before a filtered sensor changes; legal range 1–255.
- `MAX_TRAINS`, default 3: saturation value of the occupancy count; legal range 1–15.
- `TIMEOUT_CYCLES`, default 1024: cycles of occupancy with no sensor event before a fault is declared; legal range 2–2^20.
- `clk` in, 1 bit: single system clock.
- `clr` in, 1 bit: reset, asynchronous and active-high.
- `approach_raw` in, 1 bit: raw approach sensor; 1 = wheel present. Asynchronous to `clk`.
- `exit_raw` in, 1 bit: raw exit sensor; 1 = wheel present. Asynchronous to `clk`.
- `fault_ack` in, 1 bit: single-cycle operator acknowledge.
- `train` out, 1 bit: section occupied or in fault; feeds the gate controller's `train` input.
- `occupancy` out, 4 bits: current train count.
- `fault` out, 1 bit: sticky fault flag.
- `overflow` out, 1 bit: sticky; an arrival occurred while the count was at `MAX_TRAINS`.

## Operation
- **Synchronizer:** each raw sensor passes through a 2-flop synchronizer. After that, each sensor goes through an independent debouncer.
- **Debouncer:** holds a filtered value and a counter. The counter increments each cycle the synchronized value differs from the filtered value, and clears whenever they match. When it reaches `DEBOUNCE_CYCLES`, the filtered value takes the synchronized value and the counter clears.
- **Events:**
  - `arr` = a 0→1 edge on the filtered approach sensor (one-cycle pulse).
  - `dep` = a 0→1 edge on the filtered exit sensor (one-cycle pulse).
- **Count update:**
  - `arr` only: `occupancy` +1. If `occupancy` is already `MAX_TRAINS`, it holds and `overflow` sets.
  - `dep` only: `occupancy` −1. If `occupancy` is already 0, it holds at 0 and `fault` sets (unexpected departure).
  - `arr` and `dep` in the same cycle: `occupancy` is unchanged and no flag is set.
- **FSM states:** IDLE, OCC, FAULT.
  - IDLE → OCC on an `arr` that increments the count.
  - OCC → IDLE when `occupancy` reaches 0 through `dep`.
  - Any state → FAULT on unexpected departure or on timeout.
  - FAULT → IDLE on `fault_ack` if both filtered sensors are 0. This clears `fault`, `overflow`, `occupancy` and the timer.
  - `fault_ack` in FAULT with either filtered sensor at 1 is ignored.
  - `fault_ack` in IDLE or OCC is ignored.
- **Timeout timer:**
  - Runs only in OCC.
  - Clears on any `arr`/`dep` and on leaving OCC.
  - Reaching `TIMEOUT_CYCLES` → FAULT. `occupancy` is retained.
- **In FAULT:** counting continues. `fault` stays set.
- **Output decode:** `train` = (state ≠ IDLE). `fault` = (state == FAULT) or sticky fault.

## Timing
- **Reset values:** `train`=0, `occupancy`=0, `fault`=0, `overflow`=0, state IDLE. Synchronizer flops, filtered values and all counters are 0.
- **Reset mid-operation:** `clr` asserted mid-operation discards all counts immediately, regardless of sensor levels.
- **Latency:** a raw change that is stable before edge k and stays stable updates the filtered value at edge k+1+`DEBOUNCE_CYCLES`. The resulting `occupancy`/`train` update occurs at edge k+2+`DEBOUNCE_CYCLES`, which is k+6 at default parameters.
- **Glitch rejection:** glitches shorter than `DEBOUNCE_CYCLES` synchronized cycles produce no event.
- **Timeout:** FAULT is entered on the edge where the timer equals `TIMEOUT_CYCLES` with no event in that cycle. An event in that same cycle wins, and the timer clears.
- **Registered outputs:** all outputs are registered, with no combinational path from inputs.

## Structure
- **Shared package `rail_pkg`:**
  - Detector state encoding: IDLE=0, OCC=1, FAULT=2.
  - Default `DEBOUNCE_CYCLES`, `MAX_TRAINS` and `TIMEOUT_CYCLES` constants.
  - The existing light codes RED/YELLOW/GREEN move here as well.
- **Sub-module `sensor_debounce`:** synchronizer, debouncer and rising-edge pulse, parameterized by `DEBOUNCE_CYCLES`. It is instantiated twice.
- **Top level:** count, FSM, timer and flags.

## Test plan
- **Single train:** `approach_raw` high for 10 cycles, then 50 cycles later `exit_raw` high for 10 cycles, at defaults. Required: `train` rises 6 cycles after approach and falls 6 cycles after exit. `occupancy` goes 0→1→0 and `fault`=0.
- **Glitch rejection:** 3-cycle pulses on `approach_raw`. Required: no `arr`, `occupancy`=0, `train`=0 throughout.
- **Saturation:** four separate approach pulses. Required: `occupancy`=3, `overflow`=1 after the fourth, `train`=1.
- **Unexpected departure:** exit pulse with `occupancy`=0. Required: `fault`=1, `train`=1. `fault_ack` with sensors low → IDLE, all outputs 0 on the next cycle.
- **Timeout:** `TIMEOUT_CYCLES`=20, one arrival, then no exit. Required: `fault`=1 exactly 20 cycles after the `occupancy` increment, and `occupancy` still 1. Then `fault_ack` while `exit_raw` is held high → ignored.
- **Reset mid-operation:** assert `clr` while in OCC with `occupancy`=2. Required: all outputs 0 immediately. After release with sensors low, stays IDLE.
